// File: rtl/dual_path_logic_unit.sv
// dual_path_logic_unit
//   Multi-lane registered bitwise logic unit (AND/OR/XOR/XNOR). Every beat is computed
//   twice: once with the HDL operator (primary) and once with a per-bit truth table
//   (shadow). Both copies travel through an elastic valid/ready pipeline. The two copies
//   are compared when a beat is delivered. A mismatch sets a sticky flag and bumps a
//   saturating counter.
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake (in_ready is combinational on out_ready)
//   op, a, b, fault_inj   beat payload; fault_inj flips shadow bit 0 of lane 0
//   out_valid/out_ready   output handshake
//   res                   primary-path result of the delivered beat
//   err, err_cnt, err_clr sticky mismatch flag, saturating mismatch count, sync clear
module dual_path_logic_unit #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               op,
    input  logic [LANES*WIDTH-1:0]   a,
    input  logic [LANES*WIDTH-1:0]   b,
    input  logic                     fault_inj,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   res,
    output logic                     err,
    output logic [CNT_W-1:0]         err_cnt,
    input  logic                     err_clr
);

    localparam int unsigned DW   = LANES * WIDTH;
    localparam int unsigned LAST = STAGES - 1;

    // Shadow path: truth table indexed by {op, a_bit, b_bit}.
    function automatic logic shadow_bit(input logic [1:0] f, input logic x, input logic y);
        logic r;
        r = 1'b0;
        case ({f, x, y})
            4'b00_11,
            4'b01_01, 4'b01_10, 4'b01_11,
            4'b10_01, 4'b10_10,
            4'b11_00, 4'b11_11: r = 1'b1;
            default:            r = 1'b0;
        endcase
        return r;
    endfunction

    logic [DW-1:0]     pri_c;
    logic [DW-1:0]     sha_c;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] flt_q;
    logic [STAGES-1:0] adv_c;
    logic [DW-1:0]     pri_q [STAGES];
    logic [DW-1:0]     sha_q [STAGES];
    logic              hs_c;
    logic              mis_c;

    // Primary path
    always_comb begin
        pri_c = '0;
        case (op)
            2'b00:   pri_c = a & b;
            2'b01:   pri_c = a | b;
            2'b10:   pri_c = a ^ b;
            default: pri_c = ~(a ^ b);
        endcase
    end

    // Shadow path; bit 0 is bit 0 of lane 0, the fault injection point
    always_comb begin
        sha_c = '0;
        for (int i = 0; i < int'(DW); i++) begin
            sha_c[i] = shadow_bit(op, a[i], b[i]);
        end
        sha_c[0] = sha_c[0] ^ fault_inj;
    end

    // Stage i advances if out_ready or any stage from i to the output is empty;
    // written without a chain so the advance vector has no self-dependency.
    for (genvar gi = 0; gi < int'(STAGES); gi++) begin : g_adv
        assign adv_c[gi] = out_ready || !(&vld_q[LAST:gi]);
    end

    assign in_ready  = !vld_q[0] || adv_c[0];
    assign out_valid = vld_q[LAST];
    assign res       = pri_q[LAST];

    // Pipeline registers; payload only loads when the incoming slot is valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            flt_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                pri_q[i] <= '0;
                sha_q[i] <= '0;
            end
        end else begin
            if (adv_c[0]) begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    pri_q[0] <= pri_c;
                    sha_q[0] <= sha_c;
                    flt_q[0] <= fault_inj;
                end
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (adv_c[i]) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) begin
                        pri_q[i] <= pri_q[i-1];
                        sha_q[i] <= sha_q[i-1];
                        flt_q[i] <= flt_q[i-1];
                    end
                end
            end
        end
    end

    assign hs_c  = vld_q[LAST] && out_ready;
    assign mis_c = hs_c && (pri_q[LAST] != sha_q[LAST]);

    // Error tracking; a mismatch coinciding with a clear wins over the clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (err_clr) begin
            err     <= mis_c;
            err_cnt <= CNT_W'(mis_c);
        end else if (mis_c) begin
            err <= 1'b1;
            if (err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst)
        out_valid && !out_ready |=> $stable(res) && out_valid);

    a_no_fault_equiv: assert property (@(posedge clk) disable iff (!rst)
        hs_c && !flt_q[LAST] |-> pri_q[LAST] == sha_q[LAST]);

    a_err_monotonic: assert property (@(posedge clk) disable iff (!rst)
        err && !err_clr |=> err);

    a_cnt_monotonic: assert property (@(posedge clk) disable iff (!rst)
        !err_clr |=> err_cnt >= $past(err_cnt));

endmodule

// File: tb/tb_dual_path_logic_unit.sv
module tb_dual_path_logic_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        fault_inj;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] res;
    logic        err;
    logic [1:0]  err_cnt;
    logic        err_clr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dual_path_logic_unit #(.WIDTH(8), .LANES(2), .STAGES(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .fault_inj(fault_inj), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .err(err), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                         input logic [1:0] o, input logic f);
        in_valid  = v;
        a         = aa;
        b         = bb;
        op        = o;
        fault_inj = f;
    endtask

    task automatic test_reset;
        rst = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        tick; tick;
        rst = 1'b1;
        tick;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (res !== 16'h0) begin errors++; $display("FAIL reset_res: got %h want 0000", res); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        // fill the pipe, deliver one faulted beat, then reset with two beats in flight
        drive(1'b1, 16'h00FF, 16'h0F00, 2'b01, 1'b1);
        tick;
        drive(1'b1, 16'h1234, 16'h0000, 2'b01, 1'b0);
        tick;
        drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        checks++; if (out_valid !== 1'b1 || res !== 16'h0FFF) begin errors++; $display("FAIL t1_first_out: got v=%b res=%h want v=1 res=0fff", out_valid, res); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checks++; if (err !== 1'b1 || err_cnt !== 2'd1) begin errors++; $display("FAIL t1_err_before_rst: got err=%b cnt=%0d want 1/1", err, err_cnt); end
        checks++; if (res !== 16'h1234) begin errors++; $display("FAIL t1_second_out: got %h want 1234", res); end
        drive(1'b1, 16'hBEEF, 16'hFFFF, 2'b00, 1'b0);
        tick;
        drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_async_out_valid: got %b want 0", out_valid); end
        checks++; if (res !== 16'h0) begin errors++; $display("FAIL t1_async_res: got %h want 0000", res); end
        checks++; if (err !== 1'b0 || err_cnt !== 2'd0) begin errors++; $display("FAIL t1_async_err: got err=%b cnt=%0d want 0/0", err, err_cnt); end
        tick;
        rst = 1'b1;
        tick;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL t1_after_release: got rdy=%b v=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_ops;
        out_ready = 1'b1;
        drive(1'b1, 16'hF0AA, 16'hCC0F, 2'b00, 1'b0);
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t2_early_valid: got %b want 0", out_valid); end
        drive(1'b1, 16'hF0AA, 16'hCC0F, 2'b11, 1'b0);
        tick;
        drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        checks++; if (out_valid !== 1'b1 || res !== 16'hC00A) begin errors++; $display("FAIL t2_and: got v=%b res=%h want v=1 res=c00a", out_valid, res); end
        tick;
        checks++; if (out_valid !== 1'b1 || res !== 16'hC35A) begin errors++; $display("FAIL t2_xnor: got v=%b res=%h want v=1 res=c35a", out_valid, res); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t2_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_r [4];
        exp_r[0] = 16'h0A30; exp_r[1] = 16'h5FFC; exp_r[2] = 16'h55CC; exp_r[3] = 16'hAA33;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drive(1'b1, 16'h5A3C, 16'h0FF0, 2'(k), 1'b0);
            else       drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
            tick;
            if (k >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || res !== exp_r[k-1]) begin
                    errors++; $display("FAIL b2b_op%0d: got v=%b res=%h want v=1 res=%h", k-1, out_valid, res, exp_r[k-1]);
                end
            end
        end
        tick;
        checks++; if (err !== 1'b0 || err_cnt !== 2'd0) begin errors++; $display("FAIL b2b_no_err: got err=%b cnt=%0d want 0/0", err, err_cnt); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(1'b1, 16'h1111, 16'hFFFF, 2'b00, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t3_accept0: got %b want 1", in_ready); end
        tick;
        drive(1'b1, 16'h2222, 16'hFFFF, 2'b00, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t3_accept1: got %b want 1", in_ready); end
        tick;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'h3333 + 16'(k) * 16'h1111, 16'hFFFF, 2'b00, 1'b0);
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || res !== 16'h1111) begin
                errors++; $display("FAIL t3_stall%0d: got rdy=%b v=%b res=%h want 0/1/1111", k, in_ready, out_valid, res);
            end
            tick;
        end
        drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t3_ready_follows_out_ready: got %b want 1", in_ready); end
        tick;
        checks++; if (out_valid !== 1'b1 || res !== 16'h2222) begin errors++; $display("FAIL t3_second_beat: got v=%b res=%h want 1/2222", out_valid, res); end
        tick;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL t3_drained: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_fault;
        out_ready = 1'b1;
        drive(1'b1, 16'hA5A5, 16'h0FF0, 2'b10, 1'b1);
        tick;
        drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        tick;
        checks++; if (out_valid !== 1'b1 || res !== 16'hAA55 || err !== 1'b0) begin errors++; $display("FAIL t4_deliver: got v=%b res=%h err=%b want 1/aa55/0", out_valid, res, err); end
        tick;
        checks++; if (err !== 1'b1 || err_cnt !== 2'd1) begin errors++; $display("FAIL t4_detect: got err=%b cnt=%0d want 1/1", err, err_cnt); end
    endtask

    task automatic test_saturation;
        logic [1:0] exp_cnt;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        checks++; if (err !== 1'b0 || err_cnt !== 2'd0) begin errors++; $display("FAIL t5_clear_first: got err=%b cnt=%0d want 0/0", err, err_cnt); end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(k < 5, 16'h0F0F, 16'h00FF, 2'b00, k < 5);
            tick;
            exp_cnt = (k < 2) ? 2'd0 : ((k - 1 > 3) ? 2'd3 : 2'(k - 1));
            checks++;
            if (err_cnt !== exp_cnt || err !== (k >= 2)) begin
                errors++; $display("FAIL t5_sat%0d: got err=%b cnt=%0d want err=%b cnt=%0d", k, err, err_cnt, (k >= 2), exp_cnt);
            end
        end
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        checks++; if (err !== 1'b0 || err_cnt !== 2'd0) begin errors++; $display("FAIL t5_clear: got err=%b cnt=%0d want 0/0", err, err_cnt); end
    endtask

    task automatic test_simultaneous;
        out_ready = 1'b1;
        drive(1'b1, 16'h3C3C, 16'hFFFF, 2'b01, 1'b1);
        tick;
        drive(1'b1, 16'h3C3C, 16'h0000, 2'b01, 1'b1);
        tick;
        drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        tick;
        checks++; if (err !== 1'b1 || err_cnt !== 2'd1) begin errors++; $display("FAIL t6_pre: got err=%b cnt=%0d want 1/1", err, err_cnt); end
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        checks++; if (err !== 1'b1 || err_cnt !== 2'd1) begin errors++; $display("FAIL t6_clr_and_mismatch: got err=%b cnt=%0d want 1/1", err, err_cnt); end
        tick;
        checks++; if (err !== 1'b1 || err_cnt !== 2'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL t6_hold: got err=%b cnt=%0d v=%b want 1/1/0", err, err_cnt, out_valid); end
    endtask

    initial begin
        test_reset;
        test_ops;
        test_back_to_back;
        test_backpressure;
        test_fault;
        test_saturation;
        test_simultaneous;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
